input_keypad_encoder: RTL and testbench

INPUT_KEYPAD_ENCODER -- requirements
Module: input_keypad_encoder

---
 rtl/input_keypad_encoder.sv | 172 +++++++++++++++++
 tb/tb_input_keypad_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_keypad_encoder.sv
// 4x4 keypad scanner/encoder: column scan, row debounce, one command per press toward the controller.
// Auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN; the default build issues one command per press.
module input_keypad_encoder #(
  parameter int DEB_CYC  = 16,
  parameter int SCAN_CYC = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [4:0] in_cmd,
  output logic       in_valid,
  input  logic       in_ack
);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESENT  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam int              DW         = (SCAN_CYC > 4) ? $clog2(SCAN_CYC) : 2;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_CYC - 1);
  localparam logic [7:0]      DEB_LAST   = 8'(DEB_CYC - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [11:0]     REP_LAST   = 12'(16 * DEB_CYC - 1);
`endif

  logic [3:0]    sync1_q;
  logic [3:0]    rs_q;
  logic [1:0]    state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [4:0]    cmd_q, cmd_d;
`ifdef KEYPAD_REPEAT_EN
  logic [11:0]   rep_q, rep_d;
`endif

  logic       any_low;
  logic [1:0] low_row;
  logic       row_held;

  // Rows are asynchronous to Clk; only rs_q is used for decisions.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= row_n;
      rs_q    <= sync1_q;
    end
  end

  always_comb begin
    any_low = (rs_q != 4'hF);
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_q[i]) low_row = 2'(i);
    end
  end

  assign row_held = !rs_q[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (any_low) begin
            state_d = ST_DEBOUNCE;
            row_d   = low_row;
            cnt_d   = 8'd0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!row_held) begin
          state_d = ST_SCAN;
          col_d   = 2'd0;
          dwell_d = '0;
          cnt_d   = 8'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_PRESENT;
          cnt_d   = 8'd0;
          cmd_d   = {1'b0, row_q, col_q} + 5'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_PRESENT: begin
        if (in_ack) begin
          state_d = ST_RELEASE;
          cnt_d   = 8'd0;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = 12'd0;
`endif
        end
      end
      ST_RELEASE: begin
        // Only the held column is driven, so any low row means the key is still down.
        if (any_low) begin
          cnt_d = 8'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_SCAN;
          col_d   = 2'd0;
          dwell_d = '0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`ifdef KEYPAD_REPEAT_EN
        if (row_held) begin
          if (rep_q == REP_LAST) begin
            state_d = ST_PRESENT;
            rep_d   = 12'd0;
            cnt_d   = 8'd0;
          end else begin
            rep_d = rep_q + 12'd1;
          end
        end else begin
          rep_d = 12'd0;
        end
`endif
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      dwell_q <= '0;
      cnt_q   <= 8'd0;
      cmd_q   <= 5'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // cmd_q is retained through RELEASE so a repeat re-presents the same code.
  assign col_n    = ~(4'b0001 << col_q);
  assign in_valid = (state_q == ST_PRESENT);
  assign in_cmd   = in_valid ? cmd_q : 5'd0;

endmodule

// File: tb/tb_input_keypad_encoder.sv
// Directed bench for input_keypad_encoder with a combinational 4x4 key-matrix model.
module tb_input_keypad_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_ack;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [4:0]  in_cmd;
  logic        in_valid;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_fail = 0;

  int xfer_cnt, valid_cyc, zero_err, unstable, post_xfer_valid;
  int cyc = 0;
  int last_xfer_cyc, min_gap;
  logic [4:0] last_cmd;
  logic [4:0] prev_cmd = 5'd0;
  logic       prev_v = 1'b0;

  always #5 Clk = ~Clk;

  // keys[row*4+col]: a pressed key pulls its row low while its column is driven
  assign row_n[0] = ~|(keys[3:0]   & ~col_n);
  assign row_n[1] = ~|(keys[7:4]   & ~col_n);
  assign row_n[2] = ~|(keys[11:8]  & ~col_n);
  assign row_n[3] = ~|(keys[15:12] & ~col_n);

  input_keypad_encoder dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .col_n    (col_n),
    .row_n    (row_n),
    .in_cmd   (in_cmd),
    .in_valid (in_valid),
    .in_ack   (in_ack)
  );

  task automatic clear_stats();
    xfer_cnt        = 0;
    valid_cyc       = 0;
    zero_err        = 0;
    unstable        = 0;
    post_xfer_valid = 0;
    last_xfer_cyc   = -1;
    min_gap         = 1 << 30;
    last_cmd        = 5'd0;
  endtask

  // Advance n cycles, observing at each falling edge. Inputs only change between calls,
  // so in_ack/Reset seen here are the values the preceding rising edge used.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      cyc++;
      if (prev_v && in_ack && Reset) begin
        xfer_cnt++;
        last_cmd = prev_cmd;
        if (last_xfer_cyc >= 0 && (cyc - last_xfer_cyc) < min_gap) min_gap = cyc - last_xfer_cyc;
        last_xfer_cyc = cyc;
        if (in_valid !== 1'b0) post_xfer_valid++;
      end else if (prev_v && in_valid === 1'b1 && in_cmd !== prev_cmd) begin
        unstable++;
      end
      if (in_valid === 1'b1) valid_cyc++;
      else if (in_cmd !== 5'd0) zero_err++;
      prev_v   = (in_valid === 1'b1);
      prev_cmd = in_cmd;
    end
  endtask

  task automatic do_reset();
    Reset  = 1'b0;
    keys   = 16'h0;
    in_ack = 1'b0;
    step(2);
    Reset  = 1'b1;
    prev_v = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    Reset  = 1'b0;
    keys   = 16'h0;
    in_ack = 1'b0;
    step(3);
    n_cmp++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL reset_col_n: got %b expected 1110", col_n); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %b expected 0", in_valid); end
    n_cmp++; if (in_cmd !== 5'd0) begin n_fail++; $display("FAIL reset_in_cmd: got %0d expected 0", in_cmd); end
    Reset = 1'b1;
    prev_v = 1'b0;
    clear_stats();
    for (int i = 1; i <= 16; i++) begin
      step(1);
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      n_cmp++; if (col_n !== exp_col) begin n_fail++; $display("FAIL scan_rotation[%0d]: got %b expected %b", i, col_n, exp_col); end
    end
    n_cmp++; if (valid_cyc !== 0) begin n_fail++; $display("FAIL idle_no_valid: got %0d expected 0", valid_cyc); end
  endtask

  task automatic test_single_key();
    do_reset();
    in_ack  = 1'b1;
    keys[9] = 1'b1;
    step(100);
    keys = 16'h0;
    step(60);
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL single_xfer_count: got %0d expected 1", xfer_cnt); end
    n_cmp++; if (last_cmd !== 5'd10) begin n_fail++; $display("FAIL single_cmd: got %0d expected 10", last_cmd); end
    n_cmp++; if (valid_cyc !== 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cyc); end
    n_cmp++; if (post_xfer_valid !== 0) begin n_fail++; $display("FAIL single_valid_after_xfer: got %0d expected 0", post_xfer_valid); end
    n_cmp++; if (zero_err !== 0) begin n_fail++; $display("FAIL single_cmd_zero_when_idle: got %0d expected 0", zero_err); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    keys[12] = 1'b1;
    step(80);
    keys = 16'h0;
    step(40);
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL b2b_xfer_count: got %0d expected 1", xfer_cnt); end
    n_cmp++; if (last_cmd !== 5'd13) begin n_fail++; $display("FAIL b2b_cmd: got %0d expected 13", last_cmd); end
  endtask

  task automatic test_hold_no_ack();
    bit found = 1'b0;
    do_reset();
    keys[3] = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (in_valid === 1'b1) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL hold_valid_timeout: got 0 expected 1"); end
    step(50);
    keys   = 16'h0;
    in_ack = 1'b1;
    step(40);
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL hold_xfer_count: got %0d expected 1", xfer_cnt); end
    n_cmp++; if (last_cmd !== 5'd4) begin n_fail++; $display("FAIL hold_cmd: got %0d expected 4", last_cmd); end
    n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL hold_cmd_stable: got %0d expected 0", unstable); end
    n_cmp++; if (valid_cyc !== 51) begin n_fail++; $display("FAIL hold_valid_cycles: got %0d expected 51", valid_cyc); end
  endtask

  task automatic test_bounce();
    do_reset();
    in_ack  = 1'b1;
    keys[4] = 1'b1;
    step(5);
    keys = 16'h0;
    step(1);
    n_cmp++; if (valid_cyc !== 0) begin n_fail++; $display("FAIL bounce_no_early_valid: got %0d expected 0", valid_cyc); end
    keys[4] = 1'b1;
    step(30);
    keys = 16'h0;
    step(40);
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL bounce_xfer_count: got %0d expected 1", xfer_cnt); end
    n_cmp++; if (last_cmd !== 5'd5) begin n_fail++; $display("FAIL bounce_cmd: got %0d expected 5", last_cmd); end
    n_cmp++; if (valid_cyc !== 1) begin n_fail++; $display("FAIL bounce_valid_cycles: got %0d expected 1", valid_cyc); end
  endtask

  task automatic test_multi_key();
    do_reset();
    in_ack   = 1'b1;
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    step(80);
    keys = 16'h0;
    step(40);
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL multi_row_xfer_count: got %0d expected 1", xfer_cnt); end
    n_cmp++; if (last_cmd !== 5'd7) begin n_fail++; $display("FAIL multi_row_cmd: got %0d expected 7", last_cmd); end
    do_reset();
    in_ack   = 1'b1;
    keys[11] = 1'b1;
    keys[13] = 1'b1;
    step(80);
    keys = 16'h0;
    step(40);
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL multi_col_xfer_count: got %0d expected 1", xfer_cnt); end
    n_cmp++; if (last_cmd !== 5'd14) begin n_fail++; $display("FAIL multi_col_cmd: got %0d expected 14", last_cmd); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    keys[0] = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1);
      if (in_valid === 1'b1) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rstmid_valid_timeout: got 0 expected 1"); end
    Reset  = 1'b0;
    in_ack = 1'b1;
    keys   = 16'h0;
    step(1);
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_valid: got %b expected 0", in_valid); end
    n_cmp++; if (in_cmd !== 5'd0) begin n_fail++; $display("FAIL rstmid_in_cmd: got %0d expected 0", in_cmd); end
    n_cmp++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL rstmid_col_n: got %b expected 1110", col_n); end
    Reset = 1'b1;
    step(60);
    n_cmp++; if (xfer_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_xfer: got %0d expected 0", xfer_cnt); end
  endtask

  task automatic test_repeat();
    do_reset();
    in_ack   = 1'b1;
    keys[15] = 1'b1;
    step(1000);
    keys = 16'h0;
    step(40);
    n_cmp++; if (last_cmd !== 5'd16) begin n_fail++; $display("FAIL repeat_cmd: got %0d expected 16", last_cmd); end
`ifdef KEYPAD_REPEAT_EN
    n_cmp++; if (xfer_cnt < 3) begin n_fail++; $display("FAIL repeat_xfer_count: got %0d expected at least 3", xfer_cnt); end
    n_cmp++; if (min_gap < 256) begin n_fail++; $display("FAIL repeat_interval: got %0d expected at least 256", min_gap); end
`else
    n_cmp++; if (xfer_cnt !== 1) begin n_fail++; $display("FAIL held_xfer_count: got %0d expected 1", xfer_cnt); end
`endif
  endtask

  initial begin
    Reset  = 1'b0;
    in_ack = 1'b0;
    keys   = 16'h0;
    clear_stats();
    test_reset();
    test_single_key();
    test_back_to_back();
    test_hold_no_ack();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
